pipe_delay_line: RTL and testbench
==================================

// Module: pipe_delay_line
// PURPOSE
//  Parametrised WIDTH x DEPTH register pipeline with per-stage valid and valid/ready flow control.
//  Generalised successor to the single-bit reset flop; used to delay-match pixel/gradient streams in the optical-flow datapath.
//  Bubble-collapsing: a stalled output lets upstream stages keep filling empty slots.
// PARAMETERS
//  WIDTH  8  data bits per stage
//  DEPTH  4  number of register stages (>=1); unstalled latency in cycles
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  reset      in   1                    synchronous, active-high
//  in_valid   in   1                    upstream data valid
//  in_data    in   WIDTH                upstream data
//  in_ready   out  1                    pipe accepts in_data this cycle
//  out_valid  out  1                    last stage holds valid data
//  out_data   out  WIDTH                last stage data
//  out_ready  in   1                    downstream accepts out_data
//  level      out  $clog2(DEPTH+1)      occupied stages (only with PIPE_LEVEL_EN)
// BEHAVIOUR
//  - reset: all stage valid bits=0, all stage data=0; so out_valid=0, out_data=0, in_ready=1, level=0.
//  - Reset mid-operation drops every in-flight item; nothing is emitted after reset is sampled.
//  - Stage k (0=input, DEPTH-1=output) holds vld[k], dat[k].
//  - adv[DEPTH-1] = out_ready; adv[k] = load[k+1] for k<DEPTH-1.
//  - load[k] = !vld[k] | adv[k]  (stage may take new content this cycle).
//  - in_ready = load[0]; combinational, no register in ready path.
//  - On load[k]: vld[k] <= upstream valid (in_valid for k=0, else vld[k-1]);
//    dat[k] <= upstream data only when upstream valid=1, else dat[k] holds.
//  - Without load[k]: stage holds both fields.
//  - Accept on input = in_valid & in_ready; on output = out_valid & out_ready.
//  - out_data must stay stable while out_valid=1 & out_ready=0.
//  - No stall: item accepted in cycle t appears at out_valid in cycle t+DEPTH; throughput 1/cycle.
//  - Full (all vld=1) and out_ready=0: in_ready=0. Full and out_ready=1: in_ready=1, simultaneous in/out.
//  - Empty: out_valid=0; out_ready ignored.
//  - Ordering strictly FIFO; no item duplicated or dropped except by reset.
//  - DEPTH=1 degenerates to a single register slice with in_ready = !vld[0] | out_ready.
// CONFIGURATION
//  - Macro PIPE_LEVEL_EN.
//  - Defined: level port present; registered count of valid stages.
//    Input accept alone: +1. Output accept alone: -1. Both or neither: unchanged. Reset: 0.
//    Never exceeds DEPTH and never goes below 0.
//  - Not defined: level port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pipe_pkg: default WIDTH/DEPTH constants and a level-width function returning $clog2(DEPTH+1).
//  - Sub-module pipe_stage: one WIDTH-bit data register plus valid bit, with a load input and synchronous reset.
//    Instantiated DEPTH times in a generate loop; ready chain and level counter live in the top.
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//  - Reset: hold reset 2 cycles -> out_valid=0, out_data=0x00, in_ready=1, level=0.
//  - Stream: send 0x01..0x08 back-to-back with out_ready=1 -> 0x01 at out on cycle 4 after its accept, then one per cycle in order.
//  - Backpressure: out_ready=0, offer 0x10..0x15 -> 4 accepted, in_ready=0, level=4, out_data=0x10 stable.
//    Then out_ready=1 -> in_ready=1 the same cycle and 0x11..0x15 follow in order.
//  - Bubble collapse: one item 0xA5, out_ready=0 -> reaches out after 4 cycles.
//    Then 0xB6, 0xC7 -> land in stages 2 and 1; in_ready stays 1 until all 4 stages are valid.
//  - Mid-op reset: 3 items in flight, assert reset 1 cycle -> next cycle out_valid=0, level=0, no stale output afterwards.
//  - DEPTH=1 build: alternate out_ready 1/0 on a continuous input -> no loss, no duplication, output order preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_delay_line register pipeline.
// Provides default geometry and the width of the optional occupancy counter.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_delay_line_if.sv
// Stream bundle for pipe_delay_line: upstream (in_*) and downstream (out_*) channels.
// The master drives the pipe; the slave is the pipe itself.
interface pipe_delay_line_if #(
  parameter int WIDTH = 8
);

  // A beat transfers on a rising edge where valid & ready are both 1; valid must
  // not depend on ready, and data is held stable while valid=1 and ready=0.
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: WIDTH-bit data register plus valid bit with a load enable.
// Data only updates when the incoming slot is valid, so bubbles never clobber held data.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load) begin
      vld_d = up_valid;
      if (up_valid) dat_d = up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/pipe_delay_line.sv
// WIDTH x DEPTH bubble-collapsing register pipeline with valid/ready flow control.
// Optional occupancy counter port `level` is built when PIPE_LEVEL_EN is defined.
module pipe_delay_line
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  pipe_delay_line_if.slave               bus
`ifdef PIPE_LEVEL_EN
  ,
  output logic [level_width(DEPTH)-1:0]  level
`endif
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] dat [DEPTH];

  // A stage may load if it is empty or everything below it can move; computed
  // top-down as a running OR so the ready path stays purely combinational.
  always_comb begin : ready_chain
    logic chain;
    chain = bus.out_ready;
    load  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain   = chain | ~vld[k];
      load[k] = chain;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = vld[k-1];
      assign up_data  = dat[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .load     (load[k]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .vld      (vld[k]),
      .dat      (dat[k])
    );
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];

`ifdef PIPE_LEVEL_EN
  localparam int LW = level_width(DEPTH);

  logic          in_acc;
  logic          out_acc;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    in_acc  = bus.in_valid & load[0];
    out_acc = vld[DEPTH-1] & bus.out_ready;
    level_d = level_q;
    if (in_acc && !out_acc) begin
      level_d = level_q + LW'(1);
    end else if (out_acc && !in_acc) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed bench for pipe_delay_line: DEPTH=4 main instance and a DEPTH=1 slice instance.
// Build with PIPE_LEVEL_EN defined to also exercise the level counter.
module tb_pipe_delay_line;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   last_acc_a;
  int   first_acc_a;
  int   rcv_b;
  bit   bp_done;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  pipe_delay_line_if #(.WIDTH(8)) a_if ();
  pipe_delay_line_if #(.WIDTH(8)) b_if ();

`ifdef PIPE_LEVEL_EN
  logic [2:0] a_level;
  logic [0:0] b_level;
`endif

  pipe_delay_line #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
`ifdef PIPE_LEVEL_EN
    , .level (a_level)
`endif
  );

  pipe_delay_line #(.WIDTH(8), .DEPTH(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
`ifdef PIPE_LEVEL_EN
    , .level (b_level)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic send_a(input logic [7:0] d);
    int waitc;
    bit ok;
    waitc = 0;
    ok    = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    while (!ok && waitc < 200) begin
      @(negedge clk);
      if (a_if.in_ready) ok = 1'b1;
      else               waitc++;
    end
    if (ok) begin
      exp_a.push_back(d);
      last_acc_a = cyc;
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_a timeout: got no accept expected accept of 0x%0h", d);
    end
    sync();
    a_if.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int waitc;
    bit ok;
    waitc = 0;
    ok    = 1'b0;
    b_if.in_valid = 1'b1;
    b_if.in_data  = d;
    while (!ok && waitc < 200) begin
      @(negedge clk);
      if (b_if.in_ready) ok = 1'b1;
      else               waitc++;
    end
    if (ok) exp_b.push_back(d);
    else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_b timeout: got no accept expected accept of 0x%0h", d);
    end
    sync();
    b_if.in_valid = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while (exp_a.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_a.size(), 0);
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (!reset && a_if.out_valid) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_out_unexpected: got 0x%0h expected no output", a_if.out_data);
      end else if (a_if.out_ready) begin
        check("a_out", a_if.out_data, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_if.out_valid) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_out_unexpected: got 0x%0h expected no output", b_if.out_data);
      end else if (b_if.out_ready) begin
        check("b_out", b_if.out_data, exp_b.pop_front());
        rcv_b++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rcv_b    = 0;
    bp_done  = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;

    // Reset held for two cycles.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_out_data",  a_if.out_data,  8'h00);
    check("rst_in_ready",  a_if.in_ready,  1);
    check("rst_b_out_valid", b_if.out_valid, 0);
    check("rst_b_in_ready",  b_if.in_ready,  1);
`ifdef PIPE_LEVEL_EN
    check("rst_level",   a_level, 0);
    check("rst_b_level", b_level, 0);
`endif

    // Back-to-back stream with no stall.
    sync();
    a_if.out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          send_a(8'(i));
          if (i == 1) first_acc_a = last_acc_a;
        end
        check("stream_throughput", last_acc_a - first_acc_a, 7);
      end
      begin : lat_watch
        int n;
        n = 0;
        @(negedge clk);
        while (!a_if.out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("stream_latency", cyc - first_acc_a, 4);
      end
    join
    drain_a("stream_drain");

    // Backpressure: fill while stalled, then release.
    sync();
    a_if.out_ready = 1'b0;
    fork
      begin
        for (int i = 8'h10; i <= 8'h15; i++) send_a(8'(i));
        bp_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    check("bp_in_ready_full", a_if.in_ready, 0);
    check("bp_out_valid", a_if.out_valid, 1);
    check("bp_out_data", a_if.out_data, 8'h10);
    check("bp_queued", exp_a.size(), 4);
`ifdef PIPE_LEVEL_EN
    check("bp_level_full", a_level, 4);
`endif
    repeat (3) @(negedge clk);
    check("bp_out_data_stable", a_if.out_data, 8'h10);
    sync();
    a_if.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", a_if.in_ready, 1);
    begin : bp_wait
      int n;
      n = 0;
      while (!bp_done && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    drain_a("bp_drain");

    // Bubble collapse behind a stalled head.
    sync();
    a_if.out_ready = 1'b0;
    send_a(8'hA5);
    begin : bub_watch
      int n;
      n = 0;
      @(negedge clk);
      while (!a_if.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("bubble_latency", cyc - last_acc_a, 4);
      check("bubble_head", a_if.out_data, 8'hA5);
    end
    sync();
    send_a(8'hB6);
    send_a(8'hC7);
    @(negedge clk);
    check("bubble_in_ready_3", a_if.in_ready, 1);
`ifdef PIPE_LEVEL_EN
    check("bubble_level_3", a_level, 3);
`endif
    sync();
    send_a(8'hD8);
    @(negedge clk);
    check("bubble_in_ready_full", a_if.in_ready, 0);
    check("bubble_head_stable", a_if.out_data, 8'hA5);
    sync();
    a_if.out_ready = 1'b1;
    drain_a("bubble_drain");

    // Reset while three items are in flight.
    sync();
    send_a(8'h31);
    send_a(8'h32);
    send_a(8'h33);
    reset = 1'b1;
    exp_a.delete();
    sync();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", a_if.out_valid, 0);
    check("midrst_out_data", a_if.out_data, 8'h00);
    check("midrst_in_ready", a_if.in_ready, 1);
`ifdef PIPE_LEVEL_EN
    check("midrst_level", a_level, 0);
`endif
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_stale", a_if.out_valid, 0);
    end

    // DEPTH=1 slice with alternating downstream ready.
    sync();
    fork
      begin
        for (int i = 8'h40; i < 8'h4C; i++) send_b(8'(i));
      end
      begin
        repeat (30) begin
          b_if.out_ready = ~b_if.out_ready;
          sync();
        end
        b_if.out_ready = 1'b1;
      end
    join
    begin : b_drain
      int n;
      n = 0;
      while (exp_b.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("d1_drain", exp_b.size(), 0);
    end
    check("d1_count", rcv_b, 12);
    @(negedge clk);
    check("d1_empty_out_valid", b_if.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
